// File: rtl/menu_pkg.sv
// Shared types and constants for the menu overlay.
// Colours, band limits, FSM states and widths.
package menu_pkg;

    localparam int COORD_W = 11;
    localparam int RGB_W   = 12;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [RGB_W-1:0]   rgb_t;

    localparam rgb_t C_BLACK = 12'h000;
    localparam rgb_t C_SKY   = 12'h5cf;
    localparam rgb_t C_GRASS = 12'h494;
    localparam rgb_t C_ROAD  = 12'h9ab;
    localparam rgb_t C_ITEM  = 12'hf52;
    localparam rgb_t C_SEL   = 12'hff4;
    localparam rgb_t C_FLASH = 12'hfff;

    localparam coord_t SKY_LAST     = 11'd629;
    localparam coord_t GRASS_A_LAST = 11'd646;
    localparam coord_t ROAD_LAST    = 11'd714;
    localparam coord_t GRASS_B_LAST = 11'd762;
    localparam coord_t COL_LAST     = 11'd1023;

    typedef enum logic [1:0] {
        ST_NAV     = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BAND_NONE  = 2'd0,
        BAND_SKY   = 2'd1,
        BAND_GRASS = 2'd2,
        BAND_ROAD  = 2'd3
    } band_t;

    function automatic band_t band_of(input coord_t h, input coord_t v);
        band_t b;
        b = BAND_NONE;
        if (h <= COL_LAST) begin
            if (v <= SKY_LAST)          b = BAND_SKY;
            else if (v <= GRASS_A_LAST) b = BAND_GRASS;
            else if (v <= ROAD_LAST)    b = BAND_ROAD;
            else if (v <= GRASS_B_LAST) b = BAND_GRASS;
        end
        return b;
    endfunction

endpackage

// File: rtl/menu_select_nav.sv
// Menu navigation: button edges, pending flags, FSM,
// selection index, confirm flash counter.
module menu_nav
    import menu_pkg::*;
#(
    parameter int N_ITEMS      = 4,
    parameter int FLASH_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vblnk,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_enter,
    input  logic       menu_en,
    output logic [2:0] sel_idx,
    output logic       sel_valid,
    output logic       done,
    output state_t     state,
    output logic       flash
);

    localparam int CW = $clog2(FLASH_FRAMES) + 1;
    localparam logic [CW-1:0] LAST = CW'(FLASH_FRAMES - 1);
    localparam logic [2:0] MAX_IDX = 3'(N_ITEMS - 1);

    state_t state_n;
    logic up_q, dn_q, en_q, vb_q;
    logic pend_up, pend_dn, pend_en;
    logic eff_up, eff_dn, eff_en;
    logic vrise;
    logic nav_tick;
    logic [CW-1:0] cnt;

    assign vrise    = vblnk & ~vb_q;
    assign eff_up   = pend_up | (btn_up & ~up_q);
    assign eff_dn   = pend_dn | (btn_down & ~dn_q);
    assign eff_en   = pend_en | (btn_enter & ~en_q);
    assign nav_tick = menu_en && state == ST_NAV && vrise;
    assign done     = state == ST_DONE;

    // Input history for edge detection on buttons and vblank
    always_ff @(posedge clk) begin
        if (rst) begin
            up_q <= 1'b0;
            dn_q <= 1'b0;
            en_q <= 1'b0;
            vb_q <= 1'b0;
        end else begin
            up_q <= btn_up;
            dn_q <= btn_down;
            en_q <= btn_enter;
            vb_q <= vblnk;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_NAV;
        else     state <= state_n;
    end

    // Next-state logic; menu disable always returns to NAV
    always_comb begin
        state_n = state;
        unique case (state)
            ST_NAV:
                if (vrise && eff_en) state_n = ST_CONFIRM;
            ST_CONFIRM:
                if (vrise && cnt >= LAST) state_n = ST_DONE;
            ST_DONE:
                state_n = ST_DONE;
            default:
                state_n = ST_NAV;
        endcase
        if (!menu_en) state_n = ST_NAV;
    end

    // Sticky pending flags, only live while navigating
    always_ff @(posedge clk) begin
        if (rst || !menu_en || state != ST_NAV || vrise) begin
            pend_up <= 1'b0;
            pend_dn <= 1'b0;
            pend_en <= 1'b0;
        end else begin
            pend_up <= eff_up;
            pend_dn <= eff_dn;
            pend_en <= eff_en;
        end
    end

    // Selection moves once per frame; enter freezes it
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_idx <= 3'd0;
        end else if (nav_tick && !eff_en) begin
            if (eff_up && !eff_dn)
                sel_idx <= (sel_idx == 3'd0) ? MAX_IDX : sel_idx - 3'd1;
            else if (eff_dn && !eff_up)
                sel_idx <= (sel_idx == MAX_IDX) ? 3'd0 : sel_idx + 3'd1;
        end
    end

    // One-cycle confirm strobe
    always_ff @(posedge clk) begin
        if (rst) sel_valid <= 1'b0;
        else     sel_valid <= nav_tick && eff_en;
    end

    // Frame counter for the confirm flash, saturates at LAST
    always_ff @(posedge clk) begin
        if (rst || !menu_en || state == ST_NAV)
            cnt <= '0;
        else if (state == ST_CONFIRM && vrise && cnt < LAST)
            cnt <= cnt + CW'(1);
    end

    if (CW > 2) begin : g_phase
        assign flash = cnt[2];
    end else begin : g_nophase
        assign flash = 1'b0;
    end

endmodule

// File: rtl/menu_select.sv
// Menu overlay: two-stage pixel pipeline over a
// banded background, with a navigable item panel.
module menu_select
    import menu_pkg::*;
#(
    parameter int N_ITEMS      = 4,
    parameter int RECT_X       = 411,
    parameter int RECT_Y       = 84,
    parameter int RECT_W       = 200,
    parameter int ITEM_H       = 64,
    parameter int ITEM_GAP     = 8,
    parameter int FLASH_FRAMES = 30
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [10:0]  hcount_in,
    input  logic [10:0]  vcount_in,
    input  logic         hsync_in,
    input  logic         vsync_in,
    input  logic         hblnk_in,
    input  logic         vblnk_in,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         btn_enter,
    input  logic         menu_en,
    output logic [10:0]  hcount_out,
    output logic [10:0]  vcount_out,
    output logic         hsync_out,
    output logic         vsync_out,
    output logic         hblnk_out,
    output logic         vblnk_out,
    output logic [11:0]  rgb_out,
    output logic [2:0]   sel_idx,
    output logic         sel_valid,
    output logic         done
);

    localparam int PITCH = ITEM_H + ITEM_GAP;
    localparam coord_t PX0 = coord_t'(RECT_X);
    localparam coord_t PX1 = coord_t'(RECT_X + RECT_W - 1);
    localparam coord_t PY0 = coord_t'(RECT_Y);
    localparam coord_t PY1 = coord_t'(RECT_Y + N_ITEMS * PITCH - ITEM_GAP - 1);
    localparam coord_t IH  = coord_t'(ITEM_H);

    state_t state;
    logic   flash;

    menu_nav #(
        .N_ITEMS      (N_ITEMS),
        .FLASH_FRAMES (FLASH_FRAMES)
    ) u_nav (
        .clk       (clk),
        .rst       (rst),
        .vblnk     (vblnk_in),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_enter (btn_enter),
        .menu_en   (menu_en),
        .sel_idx   (sel_idx),
        .sel_valid (sel_valid),
        .done      (done),
        .state     (state),
        .flash     (flash)
    );

    logic   pan_d;
    logic   hit_d;
    logic [2:0] idx_d;
    coord_t top;

    coord_t hc1, vc1;
    logic   hs1, vs1, hb1, vb1;
    band_t  band1;
    logic   pan1, hit1;
    logic [2:0] idx1;

    rgb_t   item_rgb;
    rgb_t   rgb_d;

    // Stage-1 region decode: panel box and which item row
    always_comb begin
        pan_d = menu_en
             && hcount_in >= PX0 && hcount_in <= PX1
             && vcount_in >= PY0 && vcount_in <= PY1;
        idx_d = 3'd0;
        hit_d = 1'b0;
        top   = '0;
        for (int k = 0; k < N_ITEMS; k++) begin
            top = coord_t'(RECT_Y + k * PITCH);
            if (vcount_in >= top && vcount_in < top + IH) begin
                idx_d = 3'(k);
                hit_d = 1'b1;
            end
        end
    end

    // Stage 1: timing plus region flags
    always_ff @(posedge clk) begin
        if (rst) begin
            hc1   <= '0;
            vc1   <= '0;
            hs1   <= 1'b0;
            vs1   <= 1'b0;
            hb1   <= 1'b0;
            vb1   <= 1'b0;
            band1 <= BAND_NONE;
            pan1  <= 1'b0;
            hit1  <= 1'b0;
            idx1  <= 3'd0;
        end else begin
            hc1   <= hcount_in;
            vc1   <= vcount_in;
            hs1   <= hsync_in;
            vs1   <= vsync_in;
            hb1   <= hblnk_in;
            vb1   <= vblnk_in;
            band1 <= band_of(hcount_in, vcount_in);
            pan1  <= pan_d;
            hit1  <= hit_d;
            idx1  <= idx_d;
        end
    end

    // Stage-2 colour choice; panel only overrides sky
    always_comb begin
        if (idx1 != sel_idx)
            item_rgb = C_ITEM;
        else if (state == ST_CONFIRM && flash)
            item_rgb = C_FLASH;
        else
            item_rgb = C_SEL;
        rgb_d = C_BLACK;
        if (!(hb1 || vb1)) begin
            unique case (band1)
                BAND_SKY:   rgb_d = (pan1 && hit1) ? item_rgb : C_SKY;
                BAND_GRASS: rgb_d = C_GRASS;
                BAND_ROAD:  rgb_d = C_ROAD;
                BAND_NONE:  rgb_d = C_BLACK;
                default:    rgb_d = C_BLACK;
            endcase
        end
    end

    // Stage 2: aligned outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= C_BLACK;
        end else begin
            hcount_out <= hc1;
            vcount_out <= vc1;
            hsync_out  <= hs1;
            vsync_out  <= vs1;
            hblnk_out  <= hb1;
            vblnk_out  <= vb1;
            rgb_out    <= rgb_d;
        end
    end

endmodule

// File: tb/tb_menu_select.sv
// Scoreboard bench for menu_select: a frame-level
// model predicts pixels, selection and confirm flow.
module tb_menu_select;

    localparam int N  = 4;
    localparam int RX = 411;
    localparam int RY = 84;
    localparam int RW = 200;
    localparam int IH = 64;
    localparam int IG = 8;
    localparam int FF = 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [10:0] hc = '0, vc = '0;
    logic        hs = 0, vs = 0, hb = 0, vb = 0;
    logic        bu = 0, bd = 0, be = 0, en = 0;
    logic [10:0] hc_o, vc_o;
    logic        hs_o, vs_o, hb_o, vb_o;
    logic [11:0] rgb_o;
    logic [2:0]  sel_idx;
    logic        sel_valid, done;

    menu_select #(
        .N_ITEMS(N), .RECT_X(RX), .RECT_Y(RY), .RECT_W(RW),
        .ITEM_H(IH), .ITEM_GAP(IG), .FLASH_FRAMES(FF)
    ) dut (
        .clk(clk), .rst(rst),
        .hcount_in(hc), .vcount_in(vc),
        .hsync_in(hs), .vsync_in(vs),
        .hblnk_in(hb), .vblnk_in(vb),
        .btn_up(bu), .btn_down(bd), .btn_enter(be),
        .menu_en(en),
        .hcount_out(hc_o), .vcount_out(vc_o),
        .hsync_out(hs_o), .vsync_out(vs_o),
        .hblnk_out(hb_o), .vblnk_out(vb_o),
        .rgb_out(rgb_o), .sel_idx(sel_idx),
        .sel_valid(sel_valid), .done(done)
    );

    typedef struct {
        logic [25:0] tim;
        logic [11:0] rgb;
        int          due;
    } exp_t;

    exp_t q[$];
    int tests = 0, fails = 0, cyc = 0;
    int pulses = 0, doubles = 0;

    int m_sel = 0, m_frames = 0, m_valid = 0;
    bit m_conf = 0, m_pu = 0, m_pd = 0, m_pe = 0;
    bit m_pvb = 0, m_pbu = 0, m_pbd = 0, m_pbe = 0;
    logic en_req = 1'b0;

    task automatic check(input string n, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic logic [11:0] model_rgb(input int h, input int v,
                                              input bit blank, input bit on);
        int off, k;
        if (blank || h > 1023) return 12'h000;
        if (v <= 629) begin
            if (on && h >= RX && h < RX + RW && v >= RY
                && v < RY + N * (IH + IG) - IG) begin
                off = v - RY;
                if (off % (IH + IG) < IH) begin
                    k = off / (IH + IG);
                    if (k != m_sel) return 12'hf52;
                    if (m_conf && m_frames < FF && (m_frames / 4) % 2 == 1)
                        return 12'hfff;
                    return 12'hff4;
                end
            end
            return 12'h5cf;
        end
        if (v <= 646) return 12'h494;
        if (v <= 714) return 12'h9ab;
        if (v <= 762) return 12'h494;
        return 12'h000;
    endfunction

    task automatic drive(input logic [10:0] h, input logic [10:0] v,
                         input logic hbi, input logic vbi,
                         input logic [2:0] btn, input bit push);
        exp_t e;
        bit eu, ed, ee;
        @(negedge clk);
        hc = h; vc = v; hb = hbi; vb = vbi;
        hs = 1'($urandom_range(0, 1));
        vs = 1'($urandom_range(0, 1));
        bu = btn[0]; bd = btn[1]; be = btn[2];
        en = en_req;
        e.rgb = model_rgb(int'(h), int'(v), hbi || vbi, en_req);
        e.tim = {h, v, hs, vs, hbi, vbi};
        e.due = cyc + 2;
        eu = btn[0] && !m_pbu;
        ed = btn[1] && !m_pbd;
        ee = btn[2] && !m_pbe;
        if (!en_req) begin
            m_conf = 0; m_frames = 0;
            m_pu = 0; m_pd = 0; m_pe = 0;
        end else begin
            if (!m_conf) begin
                m_pu |= eu; m_pd |= ed; m_pe |= ee;
            end
            if (vbi && !m_pvb) begin
                if (m_conf) m_frames++;
                else begin
                    if (m_pe) begin
                        m_conf = 1; m_frames = 0; m_valid++;
                    end else if (m_pu && !m_pd) m_sel = (m_sel + N - 1) % N;
                    else if (m_pd && !m_pu) m_sel = (m_sel + 1) % N;
                    m_pu = 0; m_pd = 0; m_pe = 0;
                end
            end
        end
        m_pvb = vbi; m_pbu = btn[0]; m_pbd = btn[1]; m_pbe = btn[2];
        if (push) q.push_back(e);
    endtask

    task automatic pix(input int h, input int v);
        drive(11'(h), 11'(v), 1'b0, 1'b0, 3'b000, 1'b1);
    endtask

    task automatic vblank();
        for (int i = 0; i < 3; i++)
            drive(11'($urandom_range(0, 1100)), 11'($urandom_range(763, 805)),
                  1'($urandom_range(0, 1)), 1'b1, 3'b000, 1'b1);
    endtask

    task automatic frame(input int npix, input int up_at,
                         input int dn_at, input int en_at);
        logic [10:0] h, v;
        logic hbi;
        for (int i = 0; i < npix; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                h = 11'(RX - 8 + $urandom_range(0, RW + 16));
                v = 11'(RY - 4 + $urandom_range(0, N * (IH + IG) + 8));
            end else begin
                h = 11'($urandom_range(0, 1100));
                v = 11'($urandom_range(0, 800));
            end
            hbi = ($urandom_range(0, 7) == 0);
            drive(h, v, hbi, 1'b0, {i == en_at, i == dn_at, i == up_at}, 1'b1);
        end
        pix(420, RY + m_sel * (IH + IG) + 20);
        pix(420, RY + ((m_sel + 1) % N) * (IH + IG) + 5);
        vblank();
    endtask

    task automatic st_check(input string n);
        @(posedge clk); #1;
        check({n, "_sel"}, int'(sel_idx), m_sel);
        check({n, "_done"}, int'(done), int'(m_conf && m_frames >= FF));
    endtask

    task automatic do_reset();
        int guard = 0;
        while (q.size() > 0 && guard < 10) begin
            drive(11'd0, 11'd0, 1'b1, 1'b0, 3'b000, 1'b0);
            guard++;
        end
        @(negedge clk);
        rst = 1'b1; hs = 1; vs = 1; hc = 11'd500; vc = 11'd50;
        hb = 0; vb = 0; bu = 0; bd = 0; be = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rgb", int'(rgb_o), 0);
        check("rst_hsync", int'(hs_o), 0);
        check("rst_hcount", int'(hc_o), 0);
        check("rst_sel", int'(sel_idx), 0);
        check("rst_done", int'(done), 0);
        check("rst_valid", int'(sel_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        m_sel = 0; m_conf = 0; m_frames = 0;
        m_pu = 0; m_pd = 0; m_pe = 0;
        m_pvb = 0; m_pbu = 0; m_pbd = 0; m_pbe = 0;
    endtask

    initial begin
        exp_t e;
        bit prev_sv = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                check("pix_late", e.due, cyc);
                check("pix_rgb", int'(rgb_o), int'(e.rgb));
                check("pix_timing",
                      int'({hc_o, vc_o, hs_o, vs_o, hb_o, vb_o}), int'(e.tim));
            end
            if (sel_valid) begin
                pulses++;
                if (prev_sv) doubles++;
                check("sel_hold", int'(sel_idx), m_sel);
            end
            prev_sv = sel_valid;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        do_reset();

        en_req = 1'b0;
        pix(500, 50);
        pix(100, 700);
        st_check("init");

        en_req = 1'b1;
        drive(11'd0, 11'd0, 1'b1, 1'b0, 3'b000, 1'b1);
        pix(420, 100);
        pix(420, RY + IH + IG);
        pix(420, 150);
        drive(11'd420, 11'd100, 1'b1, 1'b0, 3'b000, 1'b1);
        pix(100, 700);
        pix(1100, 50);
        pix(10, 800);
        pix(30, 640);

        pix(420, 100); pix(600, 300);
        drive(11'd420, 11'd120, 1'b0, 1'b0, 3'b001, 1'b1);
        pix(500, 200); pix(420, 100);
        st_check("up_mid");
        vblank();
        pix(420, 100);
        st_check("up_wrap");
        check("up_wrap_is3", int'(sel_idx), 3);

        frame(8, 2, 5, -1);
        st_check("updown");
        frame(8, -1, 3, -1);
        st_check("down_wrap");
        frame(8, -1, 1, -1);
        st_check("down");

        v0 = pulses;
        frame(8, 2, -1, 4);
        st_check("enter");
        check("valid_once", pulses, v0 + 1);
        for (int f = 0; f < 32; f++) begin
            frame(6, 1, 3, -1);
            st_check("confirm");
        end
        check("done_reached", int'(done), 1);

        en_req = 1'b0;
        drive(11'd0, 11'd0, 1'b1, 1'b0, 3'b000, 1'b1);
        st_check("disable");
        pix(420, 100);

        en_req = 1'b1;
        drive(11'd0, 11'd0, 1'b1, 1'b0, 3'b000, 1'b1);
        frame(6, -1, -1, 2);
        for (int f = 0; f < 5; f++) frame(6, -1, -1, -1);
        st_check("pre_rst");
        v0 = pulses;
        do_reset();
        check("rst_no_valid", pulses, v0);
        en_req = 1'b1;
        frame(6, 2, -1, -1);
        st_check("post_rst_nav");

        for (int f = 0; f < 60; f++) begin
            en_req = ($urandom_range(0, 9) != 0);
            drive(11'd0, 11'd0, 1'b1, 1'b0, 3'b000, 1'b1);
            frame(int'($urandom_range(6, 14)),
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1,
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1,
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 5)) : -1);
            st_check("rand");
        end

        repeat (4) drive(11'd0, 11'd0, 1'b1, 1'b0, 3'b000, 1'b0);
        check("queue_drained", q.size(), 0);
        check("valid_single", doubles, 0);
        check("valid_count", pulses, m_valid);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/menu_select.md
MENU_SELECT -- requirements
Module: menu_select

Interface
REQ-001 Parameters (name, default, meaning): N_ITEMS, 4, menu item count (2..8); RECT_X, 411, panel left column; RECT_Y, 84, panel top row; RECT_W, 200, panel width in pixels; ITEM_H, 64, item height; ITEM_GAP, 8, vertical gap between items; FLASH_FRAMES, 30, frame count of the confirm flash.
REQ-002 Ports (name, direction, width, meaning): clk in 1 pixel clock; rst in 1 synchronous active-high reset; hcount_in/vcount_in in 11 pixel position; hsync_in/vsync_in/hblnk_in/vblnk_in in 1 timing; btn_up/btn_down/btn_enter in 1 debounced level buttons; menu_en in 1 menu active; hcount_out/vcount_out out 11; hsync_out/vsync_out/hblnk_out/vblnk_out out 1; rgb_out out 12 RGB444; sel_idx out 3 current item; sel_valid out 1 one-cycle confirm pulse; done out 1 confirm finished.

Function
REQ-003 All timing outputs are the inputs delayed by exactly 2 clk; rgb_out is aligned to those outputs.
REQ-004 Stage 1 registers timing plus region flags (band, in-panel, item index, in-item); stage 2 selects the colour.
REQ-005 Blanking (hblnk or vblnk of the pixel) gives rgb 12'h000.
REQ-006 Background bands: rows 0..629 sky 12'h5cf; 630..646 and 715..762 grass 12'h494; 647..714 road 12'h9ab; other rows 12'h000; all columns 0..1023.
REQ-007 Panel: rows RECT_Y .. RECT_Y+N_ITEMS*(ITEM_H+ITEM_GAP)-ITEM_GAP-1, columns RECT_X..RECT_X+RW-1. The panel overrides sky only, and only when menu_en=1.
REQ-008 Item k occupies rows RECT_Y+k*(ITEM_H+ITEM_GAP) for ITEM_H rows. Gap rows inside the panel are sky.
REQ-009 Item colours: unselected 12'hf52; selected 12'hff4; selected in CONFIRM on odd flash phase 12'hfff.
REQ-010 Buttons are rising-edge detected every clk. Each detected edge sets a sticky pending flag (up, down, enter).
REQ-011 Pending flags are consumed on the rising edge of vblnk_in. Selection therefore changes only between frames.
REQ-012 NAV state, at vblnk rise:
- up only: sel_idx decrements, 0 wraps to N_ITEMS-1.
- down only: sel_idx increments, N_ITEMS-1 wraps to 0.
- up and down both pending: no change.
- enter pending: takes priority over up/down; go to CONFIRM and pulse sel_valid for 1 clk with sel_idx stable.
- All pending flags clear after consumption.
REQ-013 CONFIRM state:
- A frame counter increments at each vblnk rise.
- Flash phase = counter bit 2 (toggles every 4 frames).
- Button edges are ignored and flags are held clear.
- When the counter reaches FLASH_FRAMES-1: go to DONE.
REQ-014 DONE: done=1, panel drawn with static selected colour, buttons ignored.
REQ-015 menu_en=0 in any state:
- FSM goes to NAV next clk.
- Flags clear, counter clears.
- sel_idx holds its value.
- done=0.
- Only background is drawn.
REQ-016 Frame counter width is ceil(log2(FLASH_FRAMES))+1, saturating, never wraps.

Reset
REQ-017 rst (synchronous) sets:
- all outputs 0, sel_idx 0, state NAV;
- pending flags, edge-detect history and frame counter 0;
- pipeline contents 0.
Reset mid-CONFIRM aborts with no sel_valid.

Structure
REQ-018 Shared package menu_pkg holds the colour constants, band row limits, FSM state encoding (NAV, CONFIRM, DONE) and the 11-bit/12-bit width constants.
REQ-019 One sub-module, menu_nav: button edge detection, pending flags, FSM, sel_idx, frame counter, sel_valid and done. The top module holds the two-stage pixel pipeline.

Verification
REQ-020 Reset, then hcount=500, vcount=50, blanking low -> rgb_out 12'h5cf two clk later; sel_idx=0.
REQ-021 menu_en=1, pixel (420, 100) -> rgb 12'hff4. Pixel (420, 84+72) -> 12'hf52 (item 1). Pixel (420, 150) -> 12'h5cf (gap row).
REQ-022 One btn_up pulse mid-frame -> sel_idx stays 0 until vblnk rise, then becomes 3. Up and down in the same frame -> sel_idx unchanged.
REQ-023 btn_enter -> one sel_valid pulse at vblnk rise with sel_idx held. Selected item alternates 12'hff4/12'hfff every 4 frames. done=1 after 30 frames.
REQ-024 In CONFIRM, pulse rst -> sel_valid stays 0, state NAV, sel_idx=0. menu_en=0 in DONE -> done=0 next clk; pixel (420, 100) shows 12'h5cf.
REQ-025 Pixel (100, 700) gives 12'h9ab. Any pixel with hblnk_in=1 gives 12'h000. Output hsync equals input hsync delayed 2 clk throughout.
